// File: rtl/factor_judge.sv
// factor_judge: latches the local two-factor answer, checks it against the
// current composite question with a sequential shift-add multiplier, and
// arbitrates the round result against the opponent's completion pulse.
module factor_judge #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         STATE,
    input  logic [2*WIDTH-1:0] QUE_VAL,
    input  logic [WIDTH-1:0]   ANS_A,
    input  logic [WIDTH-1:0]   ANS_B,
    input  logic               ANS_VALID,
    input  logic               OPP_DONE,
    output logic [1:0]         JUDG,
    output logic               WRONG,
    output logic               LOC_DONE,
    output logic               BUSY
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    // Controller state codes we react to; everything else is a result state.
    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;

    // Judgment codes seen by the controller.
    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_WIN  = 2'b01;
    localparam logic [1:0] J_LOSE = 2'b10;
    localparam logic [1:0] J_DRAW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_MUL,
        S_CMP,
        S_DONE
    } fsm_t;

    fsm_t state, state_nx;

    // Latched factors (kept intact for the trivial-factor check) and the
    // working copies that the shift-add multiplier consumes.
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    cnt;
    logic             opp_seen;

    logic             load, step, correct;
    logic [1:0]       judg_nx;
    logic             wrong_nx, loc_done_nx, opp_seen_nx;

    // A factor of 0 or 1 never counts, even if the product matches.
    assign correct = (prod == QUE_VAL) && (a_q > WIDTH'(1)) && (b_q > WIDTH'(1));

    assign BUSY = (state == S_MUL);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state, result and datapath-control decode.
    always_comb begin
        state_nx    = state;
        judg_nx     = JUDG;
        wrong_nx    = 1'b0;
        loc_done_nx = 1'b0;
        opp_seen_nx = opp_seen;
        load        = 1'b0;
        step        = 1'b0;

        if (STATE == ST_READY) begin
            // Round clear beats everything else, in every FSM state.
            state_nx    = S_IDLE;
            judg_nx     = J_NONE;
            opp_seen_nx = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (STATE == ST_QUESTION || STATE == ST_INPUT)
                        state_nx = S_ARMED;
                end
                S_ARMED: begin
                    // Opponent finishing first wins outright, even before INPUT.
                    if (OPP_DONE) begin
                        judg_nx  = J_LOSE;
                        state_nx = S_DONE;
                    end else if (ANS_VALID && STATE == ST_INPUT) begin
                        load     = 1'b1;
                        state_nx = S_MUL;
                    end
                end
                S_MUL: begin
                    step = 1'b1;
                    if (OPP_DONE)
                        opp_seen_nx = 1'b1;
                    if (cnt == CW'(1))
                        state_nx = S_CMP;
                end
                S_CMP: begin
                    if (correct) begin
                        judg_nx     = (opp_seen || OPP_DONE) ? J_DRAW : J_WIN;
                        loc_done_nx = 1'b1;
                        state_nx    = S_DONE;
                    end else if (opp_seen || OPP_DONE) begin
                        // Wrong, but the round is already lost: no retry pulse.
                        judg_nx  = J_LOSE;
                        state_nx = S_DONE;
                    end else begin
                        wrong_nx    = 1'b1;
                        opp_seen_nx = 1'b0;
                        state_nx    = S_ARMED;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Shift-add multiplier: one bit of B per cycle, LSB first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q  <= '0;
            b_q  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            prod <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_q  <= ANS_A;
            b_q  <= ANS_B;
            a_sh <= {{WIDTH{1'b0}}, ANS_A};
            b_sh <= ANS_B;
            prod <= '0;
            cnt  <= CW'(WIDTH);
        end else if (step) begin
            if (b_sh[0])
                prod <= prod + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
        end
    end

    // Registered result level, one-cycle pulses and the opponent-seen flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            JUDG     <= J_NONE;
            WRONG    <= 1'b0;
            LOC_DONE <= 1'b0;
            opp_seen <= 1'b0;
        end else begin
            JUDG     <= judg_nx;
            WRONG    <= wrong_nx;
            LOC_DONE <= loc_done_nx;
            opp_seen <= opp_seen_nx;
        end
    end

endmodule
